inv_sub_shift_state: RTL and testbench

Decryption-side counterpart of the key-word substitution block: takes a 128-bit AES state, runs every byte through the inverse S-box held in a single-port BRAM, and applies InvShiftRows, producing the InvSubBytes∘InvShiftRows result used by each inverse-cipher round. It sits in the decryption datapath between AddRoundKey and InvMixColumns. It uses the same request/one-cycle-valid handshake as the encryption-side key helpers.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/xilinx_single_port_ram_read_first.sv | 43 ++++
 rtl/inv_sub_shift_state.sv | 127 ++++++++++++
 tb/tb_inv_sub_shift_state.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the decryption-side byte substitution block.
// Optional build macro: INV_SHIFT_ROWS_EN (when defined, inv_shift_dest
// applies the InvShiftRows permutation; otherwise it is the identity).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } inv_sub_shift_state_t;

  localparam int AES_STATE_BYTES = 16;
  localparam int SBOX_LATENCY    = 2;

  // Inverse S-box image, byte 0 first.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Destination byte index for input byte n (row n%4, column n/4).
  function automatic logic [3:0] inv_shift_dest(input logic [3:0] n);
`ifdef INV_SHIFT_ROWS_EN
    logic [1:0] row;
    logic [1:0] col;
    row = n[1:0];
    col = n[3:2];
    // Two-bit add wraps modulo 4: output column = (c + r) % 4.
    return {col + row, row};
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM, high-performance mode (two-cycle read
// latency: array read register plus an output register with a synchronous
// reset). The write port is tied off in this design, so the array is a
// read-only image; a non-empty INIT_FILE selects the inverse S-box image.
module xilinx_single_port_ram_read_first
  import aes_pkg::*;
#(
  parameter int    RAM_WIDTH = 8,
  parameter int    RAM_DEPTH = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] w_rom;
  logic [RAM_WIDTH-1:0] r_ram_data;
  logic [RAM_WIDTH-1:0] r_douta;

  if (INIT_FILE != "") begin : g_image
    assign w_rom = INV_SBOX[addra];
  end else begin : g_blank
    assign w_rom = '0;
  end

  // First stage: array read register.
  always_ff @(posedge clka) begin
    if (ena) r_ram_data <= w_rom;
  end

  // Second stage: output register, cleared by the port reset.
  always_ff @(posedge clka) begin
    if (rsta)        r_douta <= '0;
    else if (regcea) r_douta <= r_ram_data;
  end

  assign douta = r_douta;

endmodule

// File: rtl/inv_sub_shift_state.sv
// InvSubBytes followed by InvShiftRows on a 128-bit AES state, one byte per
// cycle through a two-cycle-latency inverse S-box BRAM.
// Optional build macro: INV_SHIFT_ROWS_EN (defined = permutation applied,
// undefined = pure InvSubBytes; timing is identical).
//
// Handshake: new_state_in is a request sampled only while idle (busy_out
// low); on the accepting edge state_in is captured and may change afterwards.
// Requests while busy are dropped, not queued. Completion is a one-cycle
// valid_out pulse 19 edges after acceptance; result_out holds until the next
// completion.
module inv_sub_shift_state
  import aes_pkg::*;
#(
  parameter string INIT_FILE = "inv_byte_sub_table.mem"
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 new_state_in,
  input  logic [15:0][7:0]     state_in,
  output logic                 busy_out,
  output logic [15:0][7:0]     result_out,
  output logic                 valid_out,
  output inv_sub_shift_state_t o_dbg_state
);

  inv_sub_shift_state_t r_state;
  logic [3:0]           r_idx;
  logic [1:0]           r_drain;
  logic                 r_run;
  logic [15:0][7:0]     r_saved;
  logic [7:0]           r_scratch [AES_STATE_BYTES];
  logic [15:0][7:0]     r_result;
  logic                 r_valid;
  logic                 r_pipe_vld  [SBOX_LATENCY];
  logic [3:0]           r_pipe_dest [SBOX_LATENCY];

  logic [7:0]           w_addr;
  logic [7:0]           w_ram_dout;
  logic [15:0][7:0]     w_scratch_flat;

  // Byte n of the FIPS ordering lives at state_in[15-n].
  assign w_addr = r_saved[4'd15 - r_idx];

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH (8),
    .RAM_DEPTH (256),
    .INIT_FILE (INIT_FILE)
  ) u_inv_sbox (
    .clka   (clk_in),
    .ena    (1'b1),
    .rsta   (~rst_n_in),
    .regcea (1'b1),
    .addra  (w_addr),
    .douta  (w_ram_dout)
  );

  // Pack the scratch bytes back into the FIPS-ordered result vector.
  always_comb begin
    w_scratch_flat = '0;
    for (int i = 0; i < AES_STATE_BYTES; i++) begin
      w_scratch_flat[AES_STATE_BYTES-1-i] = r_scratch[i];
    end
  end

  // Control FSM, destination-index pipeline and scratch capture.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_drain  <= '0;
      r_run    <= 1'b0;
      r_saved  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < AES_STATE_BYTES; i++) r_scratch[i] <= '0;
      for (int i = 0; i < SBOX_LATENCY; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_dest[i] <= '0;
      end
    end else begin
      // r_run blocks acceptance on the first edge after reset release.
      r_run   <= 1'b1;
      r_valid <= 1'b0;

      // Destination index follows the address through the BRAM latency.
      r_pipe_vld[0]  <= (r_state == ISSUE);
      r_pipe_dest[0] <= inv_shift_dest(r_idx);
      r_pipe_vld[1]  <= r_pipe_vld[0];
      r_pipe_dest[1] <= r_pipe_dest[0];
      if (r_pipe_vld[1]) r_scratch[r_pipe_dest[1]] <= w_ram_dout;

      case (r_state)
        IDLE: begin
          if (new_state_in && r_run) begin
            r_saved <= state_in;
            r_idx   <= '0;
            for (int i = 0; i < AES_STATE_BYTES; i++) r_scratch[i] <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_drain <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_drain <= r_drain + 2'd1;
          if (r_drain == 2'(SBOX_LATENCY - 1)) r_state <= OUTPUT;
        end
        OUTPUT: begin
          r_result <= w_scratch_flat;
          r_valid  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_out    = (r_state != IDLE);
  assign result_out  = r_result;
  assign valid_out   = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inv_sub_shift_state.sv
// Self-checking bench for inv_sub_shift_state: an inverse S-box derived from
// GF(2^8) arithmetic, a transaction-level timing model and a per-cycle
// compare process, plus directed literal checks.
module tb_inv_sub_shift_state;
  import aes_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 new_state_in = 1'b0;
  logic [15:0][7:0]     state_in = '0;
  logic                 busy_out;
  logic [15:0][7:0]     result_out;
  logic                 valid_out;
  inv_sub_shift_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  inv_sub_shift_state dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .new_state_in (new_state_in),
    .state_in     (state_in),
    .busy_out     (busy_out),
    .result_out   (result_out),
    .valid_out    (valid_out),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- reference inverse S-box ----------------
  logic [7:0] inv_tbl [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_inv_tbl();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++)
          if (gf_mul(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tbl[s] = x;
    end
  endtask

  // Expected result: byte n (row n%4, col n/4) goes to (row, (col+row)%4).
  function automatic logic [127:0] model_out(input logic [127:0] st);
    logic [127:0] res;
    int r, c, m;
    res = '0;
    for (int n = 0; n < 16; n++) begin
      r = n % 4;
      c = n / 4;
`ifdef INV_SHIFT_ROWS_EN
      m = r + 4 * ((c + r) % 4);
`else
      m = n;
`endif
      res[8*(15-m) +: 8] = inv_tbl[st[8*(15-n) +: 8]];
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- transaction timing model ----------------
  // Accept when idle (not on the first edge after reset); result 19 edges
  // after acceptance; busy for the 19 cycles following acceptance.
  logic [127:0] exp_q[$];
  int           m_cnt    = -1;
  bit           m_armed  = 1'b0;
  logic         m_valid  = 1'b0;
  logic         m_busy   = 1'b0;
  logic [127:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = -1; m_armed = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_result = '0;
      exp_q.delete();
    end else begin
      m_valid = 1'b0;
      if (m_cnt == 18) begin
        m_valid = 1'b1;
        if (exp_q.size() > 0) m_result = exp_q.pop_front();
        m_cnt = -1;
      end else if (m_cnt >= 0) begin
        m_cnt++;
      end else if (m_armed && new_state_in) begin
        m_cnt = 0;
        exp_q.push_back(model_out(state_in));
      end
      m_armed = 1'b1;
      m_busy  = (m_cnt >= 0);
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (valid_out !== m_valid || busy_out !== m_busy || result_out !== m_result) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: got valid=%b busy=%b result=%h, expected valid=%b busy=%b result=%h",
                 $time, valid_out, busy_out, result_out, m_valid, m_busy, m_result);
      end
    end
  end

  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One request accepted at E0; optionally change state_in after E0 and
  // pulse a second request at E5. Checks valid timing and the literal result.
  task automatic run_literal(input string name, input logic [127:0] st,
                             input logic [127:0] exp, input bit disturb);
    int got_k;
    int pulses;
    got_k = -1;
    pulses = 0;
    @(negedge clk);
    state_in = st;
    new_state_in = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        new_state_in = 1'b0;
        if (disturb) state_in = rand128();
      end
      if (disturb && k == 4) begin new_state_in = 1'b1; state_in = rand128(); end
      if (disturb && k == 5) new_state_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (got_k < 0) got_k = k;
      end
      if (got_k >= 0 && k == got_k + 1) break;
    end
    check_int({name, "_valid_edge"}, got_k, 19);
    check_int({name, "_valid_pulses"}, pulses, 1);
    check128({name, "_result"}, result_out, exp);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] S_VEC  = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef INV_SHIFT_ROWS_EN
  localparam logic [127:0] S_EXP  = 128'h000d0a0704010e0b0805020f0c090603;
`else
  localparam logic [127:0] S_EXP  = 128'h000102030405060708090a0b0c0d0e0f;
`endif
  localparam logic [127:0] ALL_63 = {16{8'h63}};
  localparam logic [127:0] ALL_52 = {16{8'h52}};

  initial begin
    int vpos [$];
    build_inv_tbl();

    // Pin the model against hand-computed values.
    check128("model_all63", model_out(ALL_63), 128'h0);
    check128("model_all00", model_out(128'h0), ALL_52);
    check128("model_svec", model_out(S_VEC), S_EXP);

    // Reset phase.
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check128("reset_result", result_out, 128'h0);
    check_int("reset_valid", int'(valid_out), 0);
    check_int("reset_busy", int'(busy_out), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Directed literal cases.
    run_literal("all63", ALL_63, 128'h0, 1'b0);
    run_literal("all00", 128'h0, ALL_52, 1'b0);
    run_literal("svec", S_VEC, S_EXP, 1'b0);
    run_literal("svec_disturb", S_VEC, S_EXP, 1'b1);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    state_in = rand128();
    new_state_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    new_state_in = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check128("midreset_result", result_out, 128'h0);
    check_int("midreset_valid", int'(valid_out), 0);
    check_int("midreset_busy", int'(busy_out), 0);
    repeat (2) @(posedge clk);
    // Request pending across the release: must not be taken on the first edge.
    state_in = ALL_63;
    new_state_in = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_int("release_edge_busy", int'(busy_out), 0);
    @(negedge clk);
    new_state_in = 1'b0;
    repeat (25) @(posedge clk);
    check_int("no_valid_after_reset", int'(valid_out), 0);
    run_literal("post_reset_all63", ALL_63, 128'h0, 1'b0);

    // Continuous request: accepts at E0 and E20, valid at E19 and E39.
    @(negedge clk);
    state_in = 128'h0;
    new_state_in = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 44; k++) begin
      @(negedge clk);
      if (valid_out) vpos.push_back(k);
    end
    new_state_in = 1'b0;
    check_int("hold_pulses", vpos.size(), 3 - 1);
    check_int("hold_first", (vpos.size() > 0) ? vpos[0] : -1, 19);
    check_int("hold_second", (vpos.size() > 1) ? vpos[1] : -1, 39);
    repeat (25) @(posedge clk);

    // Randomized requests and data, including requests while busy.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      new_state_in = ($urandom_range(0, 3) == 0);
      state_in = rand128();
    end
    @(negedge clk);
    new_state_in = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
